// File: rtl/timer_sched_if.sv
// Bus/status bundle for timer_sched.
//   master: bus side (drives tick, writes, read address; sees read data and status)
//   slave : timer_sched side
interface timer_sched_if #(
  parameter int CW = 16
);
  logic          tick;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [CW-1:0] wr_data;
  logic [4:0]    rd_addr;
  logic [CW-1:0] rd_data;
  logic          int_n;
  logic [2:0]    int_id;
  logic          busy;
  logic          ovf;

  modport master (
    output tick, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, int_n, int_id, busy, ovf
  );

  modport slave (
    input  tick, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, int_n, int_id, busy, ovf
  );
endinterface

// File: rtl/timer_sched.sv
// timer_sched: NCH software-timer channels sharing one CW-bit decrement
// datapath. Each tick starts a round-robin scan (one channel per clock);
// a channel reaching count <= 1 raises its pending flag, and the lowest
// pending channel is reported on a registered active-low interrupt.
//   clk, rst : clock, async active-high reset
//   bus      : timer_sched_if.slave (tick, write port, read port, int_n,
//              int_id, busy, ovf)
// Address map {chan[2:0], reg[1:0]}: reg0 reload, reg1 ctrl {pend,per,en},
// reg2 ack (write), reg3 count (read). Address 31: write clears ovf,
// read returns {busy, ovf}.

// Per-channel register state. The scan result arrives precomputed from the
// shared datapath; bus writes are applied last so they win on collision.
module timer_sched_chan #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          svc,       // scan visits this channel while enabled
  input  logic          svc_fire,
  input  logic [CW-1:0] svc_cnt,
  input  logic          wr_rld,
  input  logic          wr_ctrl,
  input  logic          wr_ack,
  input  logic [CW-1:0] wr_data,
  output logic [CW-1:0] rld,
  output logic [CW-1:0] cnt,
  output logic          en,
  output logic          per,
  output logic          pend
);
  // A ctrl write disabling the channel cancels that cycle's service.
  logic do_svc;
  assign do_svc = svc && !(wr_ctrl && !wr_data[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rld  <= '0;
      cnt  <= '0;
      en   <= 1'b0;
      per  <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (do_svc) begin
        cnt <= svc_cnt;
        if (svc_fire && !per) en <= 1'b0;
      end
      if (wr_ack) pend <= 1'b0;
      // fire after ack so a same-cycle fire keeps pending set
      if (do_svc && svc_fire) pend <= 1'b1;
      if (wr_rld) rld <= wr_data;
      if (wr_ctrl) begin
        en  <= wr_data[0];
        per <= wr_data[1];
        if (!en && wr_data[0]) cnt <= rld;
      end
    end
  end
endmodule

module timer_sched #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input logic         clk,
  input logic         rst,
  timer_sched_if.slave bus
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic       tick_pend, tick_pend_nxt;
  logic       ovf_r, ovf_nxt;
  logic       last;

  // Channel state arrays are always 8 wide so a 3-bit channel index is
  // exact; slots at or above NCH read as zero.
  logic [7:0][CW-1:0] rld_a, cnt_a;
  logic [7:0]         en_a, per_a, pend_a;

  logic [2:0] wr_chan, rd_chan;
  logic [1:0] wr_reg, rd_reg;
  assign wr_chan = bus.wr_addr[4:2];
  assign wr_reg  = bus.wr_addr[1:0];
  assign rd_chan = bus.rd_addr[4:2];
  assign rd_reg  = bus.rd_addr[1:0];

  // Shared decrement/reload datapath for the channel under service.
  logic [CW-1:0] cur_cnt, cur_rld, svc_cnt;
  logic          svc_fire;
  assign cur_cnt  = cnt_a[idx];
  assign cur_rld  = rld_a[idx];
  assign svc_fire = (cur_cnt <= CW'(1));
  always_comb begin
    svc_cnt = cur_cnt - CW'(1);
    if (svc_fire) begin
      if (per_a[idx]) svc_cnt = (cur_rld == '0) ? CW'(1) : cur_rld;
      else            svc_cnt = '0;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_ch
    if (i < NCH) begin : g_on
      timer_sched_chan #(.CW(CW)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .svc      ((state == SCAN) && (idx == 3'(i)) && en_a[i]),
        .svc_fire (svc_fire),
        .svc_cnt  (svc_cnt),
        .wr_rld   (bus.wr_en && wr_chan == 3'(i) && wr_reg == 2'd0),
        .wr_ctrl  (bus.wr_en && wr_chan == 3'(i) && wr_reg == 2'd1),
        .wr_ack   (bus.wr_en && wr_chan == 3'(i) && wr_reg == 2'd2),
        .wr_data  (bus.wr_data),
        .rld      (rld_a[i]),
        .cnt      (cnt_a[i]),
        .en       (en_a[i]),
        .per      (per_a[i]),
        .pend     (pend_a[i])
      );
    end else begin : g_off
      assign rld_a[i]  = '0;
      assign cnt_a[i]  = '0;
      assign en_a[i]   = 1'b0;
      assign per_a[i]  = 1'b0;
      assign pend_a[i] = 1'b0;
    end
  end

  assign last = (idx == 3'(NCH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      tick_pend <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      tick_pend <= tick_pend_nxt;
      ovf_r     <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    tick_pend_nxt = tick_pend;
    ovf_nxt       = ovf_r;
    if (bus.wr_en && bus.wr_addr == 5'd31) ovf_nxt = 1'b0;
    case (state)
      IDLE: if (bus.tick) begin
        state_nxt = SCAN;
        idx_nxt   = '0;
      end
      SCAN: if (last) begin
        idx_nxt = '0;
        // A tick on the last cycle counts as latched: restart either way.
        // If one was already waiting, the new one stays latched.
        if (tick_pend || bus.tick) tick_pend_nxt = tick_pend && bus.tick;
        else                       state_nxt     = IDLE;
      end else begin
        idx_nxt = idx + 3'd1;
        if (bus.tick) begin
          if (tick_pend) ovf_nxt       = 1'b1;
          else           tick_pend_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Interrupt outputs, one cycle behind the pending flags.
  logic [2:0] low_id;
  always_comb begin
    low_id = '0;
    for (int i = 7; i >= 0; i--)
      if (pend_a[i]) low_id = 3'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.int_n  <= 1'b1;
      bus.int_id <= '0;
    end else begin
      bus.int_n  <= ~|pend_a;
      bus.int_id <= low_id;
    end
  end

  assign bus.busy = (state == SCAN);
  assign bus.ovf  = ovf_r;

  always_comb begin
    bus.rd_data = '0;
    if (bus.rd_addr == 5'd31) bus.rd_data = CW'({bus.busy, ovf_r});
    else begin
      case (rd_reg)
        2'd0:    bus.rd_data = rld_a[rd_chan];
        2'd1:    bus.rd_data = CW'({pend_a[rd_chan], per_a[rd_chan], en_a[rd_chan]});
        2'd3:    bus.rd_data = cnt_a[rd_chan];
        default: bus.rd_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched (NCH=4, CW=16). Inputs change on the
// falling edge; outputs are sampled on the falling edge or shortly after.
module tb_timer_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  logic [15:0] d;

  always #5 clk = ~clk;

  timer_sched_if #(.CW(16)) bus ();

  timer_sched #(.NCH(4), .CW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] v);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = v;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] v);
    bus.rd_addr = a;
    #1 v = bus.rd_data;
  endtask

  task automatic tick1();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.rd_addr = '0;
    step(3);
    // reset state
    chk("rst_int_n", bus.int_n, 1);
    chk("rst_int_id", bus.int_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    step(1);

    // one-shot: ch0 reload 3
    wr(5'd0, 16'd3); wr(5'd1, 16'd1);
    rd(5'd3, d); chk("os_load", d, 3);
    tick1(); step(10);
    rd(5'd3, d); chk("os_cnt_t1", d, 2);
    tick1(); step(10);
    rd(5'd3, d); chk("os_cnt_t2", d, 1);
    tick1(); step(1);
    rd(5'd1, d); chk("os_pend", d, 3'b100);
    chk("os_int_lat", bus.int_n, 1);
    step(1);
    chk("os_int_n", bus.int_n, 0);
    chk("os_int_id", bus.int_id, 0);
    rd(5'd3, d); chk("os_cnt0", d, 0);
    tick1(); step(10);
    rd(5'd1, d); chk("os_nofire", d, 3'b100);
    rd(5'd3, d); chk("os_nofire_cnt", d, 0);
    wr(5'd2, 16'd0); step(1);
    chk("os_ack", bus.int_n, 1);

    // periodic + priority: ch2 reload 2, ch1 reload 4
    wr(5'd8, 16'd2); wr(5'd9, 16'd3);
    wr(5'd4, 16'd4); wr(5'd5, 16'd3);
    tick1(); step(10);
    tick1(); step(10);
    rd(5'd9, d); chk("per_c2_t2", d, 3'b111);
    rd(5'd5, d); chk("per_c1_t2", d, 3'b011);
    chk("per_id_t2", bus.int_id, 2);
    tick1(); step(10);
    tick1(); step(10);
    rd(5'd5, d); chk("per_c1_t4", d, 3'b111);
    rd(5'd11, d); chk("per_c2_cnt", d, 2);
    rd(5'd7, d); chk("per_c1_cnt", d, 4);
    chk("per_id_t4", bus.int_id, 1);
    wr(5'd6, 16'd0); step(1);
    chk("per_ack1_id", bus.int_id, 2);
    chk("per_ack1_n", bus.int_n, 0);
    wr(5'd10, 16'd0); step(1);
    chk("per_ack2_n", bus.int_n, 1);
    wr(5'd5, 16'd0); wr(5'd9, 16'd0);

    // reload 0 on ch3, reload 1 on ch0
    wr(5'd12, 16'd0); wr(5'd13, 16'd3);
    wr(5'd0, 16'd1); wr(5'd1, 16'd3);
    rd(5'd15, d); chk("r0_load", d, 0);
    for (int t = 0; t < 2; t++) begin
      tick1(); step(10);
      rd(5'd15, d); chk("r0_cnt", d, 1);
      rd(5'd3, d);  chk("r1_cnt", d, 1);
      rd(5'd13, d); chk("r0_pend", d, 3'b111);
      rd(5'd1, d);  chk("r1_pend", d, 3'b111);
      wr(5'd14, 16'd0); wr(5'd2, 16'd0);
    end
    wr(5'd13, 16'd0); wr(5'd1, 16'd0);
    step(1);
    chk("r_idle_int", bus.int_n, 1);

    // overrun: ticks on three consecutive cycles
    bus.tick = 1'b1; step(3); bus.tick = 1'b0;
    chk("ovf_set", bus.ovf, 1);
    chk("ovf_busy", bus.busy, 1);
    step(5);
    chk("ovf_busy_end", bus.busy, 1);
    step(1);
    chk("ovf_idle", bus.busy, 0);
    rd(5'd31, d); chk("ovf_rd", d, 2'b01);
    wr(5'd31, 16'd0);
    rd(5'd31, d); chk("ovf_clr", d, 2'b00);

    // collision: ack on ch0's fire cycle
    wr(5'd1, 16'd3);
    tick1(); wr(5'd2, 16'd0); step(5);
    rd(5'd1, d); chk("col_ack", d, 3'b111);
    wr(5'd2, 16'd0);
    rd(5'd1, d); chk("col_acked", d, 3'b011);
    // collision: disable on ch0's fire cycle
    tick1(); wr(5'd1, 16'd0); step(5);
    rd(5'd1, d); chk("col_dis", d, 3'b000);
    rd(5'd3, d); chk("col_dis_cnt", d, 1);
    chk("col_dis_int", bus.int_n, 1);

    // reset mid-scan with pending and overrun
    wr(5'd1, 16'd3); wr(5'd4, 16'd5); wr(5'd5, 16'd3);
    bus.tick = 1'b1; step(3); bus.tick = 1'b0;
    step(1);
    chk("pre_rst_int", bus.int_n, 0);
    chk("pre_rst_ovf", bus.ovf, 1);
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_int", bus.int_n, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ovf", bus.ovf, 0);
    rd(5'd4, d); chk("mid_rst_rld", d, 0);
    rd(5'd1, d); chk("mid_rst_ctrl", d, 0);
    rd(5'd3, d); chk("mid_rst_cnt", d, 0);
    rst = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
